// File: rtl/sfx_voice_scheduler_if.sv
// Sound-effect voice scheduler bus.
// Groups the sample strobe, event handshake, SRAM read port and mixer outputs.
//   slave  : the scheduler side (drives o_* signals)
//   master : the host / testbench side (drives i_* signals)
interface sfx_voice_scheduler_if;
  logic        i_tick;
  logic [19:0] i_time;
  logic        i_play_stored;
  logic        i_evt_valid;
  logic [32:0] i_evt_data;
  logic        o_evt_ready;
  logic [19:0] o_sram_addr;
  logic [15:0] i_sram_dq;
  logic [15:0] o_mix;
  logic        o_mix_valid;
  logic        o_busy;
  logic        o_overrun;
  logic [3:0]  o_active_cnt;

  modport slave (
    input  i_tick, i_time, i_play_stored, i_evt_valid, i_evt_data, i_sram_dq,
    output o_evt_ready, o_sram_addr, o_mix, o_mix_valid, o_busy, o_overrun, o_active_cnt
  );

  modport master (
    output i_tick, i_time, i_play_stored, i_evt_valid, i_evt_data, i_sram_dq,
    input  o_evt_ready, o_sram_addr, o_mix, o_mix_valid, o_busy, o_overrun, o_active_cnt
  );
endinterface

// File: rtl/sfx_voice_scheduler.sv
// Polyphonic sound-effect scheduler.
// Holds up to NUM_VOICES button events, and on every sample tick walks the slot
// table, fetches one SRAM sample per live voice, shifts it by the voice volume,
// sums and saturates the result to a 16-bit mixed sample.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : tick/time/raw-mode inputs, event valid/ready handshake,
//                  SRAM address/data, mixed sample + valid, busy/overrun/occupancy
//
// state  | meaning
// IDLE   | waiting for a tick, events accepted here only
// SCAN   | evaluate slot r_k: issue read if live, retire if expired
// WAIT   | SRAM read latency countdown
// ACC    | add shifted sample of slot r_k into the accumulator
// RAW    | issue raw read at the latched time
// DONE   | saturate and publish the mixed sample

package sound_pkg;
  // Each sound owns a 32K-sample window of the 1M-sample SRAM.
  function automatic logic [19:0] sound_addr(input logic [4:0] id);
    return {id, 15'h0000};
  endfunction

  function automatic logic [19:0] sound_length(input logic [4:0] id);
    return 20'd600 + 20'(id) * 20'd40;
  endfunction
endpackage

module sfx_voice_scheduler
  import sound_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SRAM_LAT   = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  sfx_voice_scheduler_if.slave bus
);

  localparam int KW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WW = $clog2(SRAM_LAT + 1);
  localparam logic [KW-1:0] LAST = KW'(NUM_VOICES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_ACC, S_RAW, S_DONE} state_t;

  state_t                r_state;
  logic [NUM_VOICES-1:0] r_valid;
  logic [19:0]           r_start [NUM_VOICES];
  logic [20:0]           r_end   [NUM_VOICES];
  logic [19:0]           r_base  [NUM_VOICES];
  logic [1:0]            r_vol   [NUM_VOICES];
  logic [KW-1:0]         r_k;
  logic [WW-1:0]         r_wait;
  logic [19:0]           r_time;
  logic                  r_raw;
  logic signed [19:0]    r_acc;
  logic [19:0]           r_sram_addr;
  logic [15:0]           r_mix;
  logic                  r_mix_valid;

  logic               w_free_any;
  logic [KW-1:0]      w_free_idx;
  logic [3:0]         w_cnt;
  logic               w_ready;
  logic               w_evt_store;
  logic               w_ended;
  logic               w_live;
  logic [19:0]        w_voice_addr;
  logic signed [15:0] w_dq_shift;
  logic signed [19:0] w_acc_next;
  logic [15:0]        w_sat;
  logic               w_unused_evt_bits;

  // Lowest-index free slot wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_cnt      = 4'd0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = KW'(i);
      end
      w_cnt = w_cnt + 4'(r_valid[i]);
    end
  end

  assign w_ready     = w_free_any & (r_state == S_IDLE);
  // Muted or all-zero events complete the handshake but are dropped.
  assign w_evt_store = bus.i_evt_valid & w_ready & ~bus.i_evt_data[32] & (|bus.i_evt_data);
  assign w_unused_evt_bits = ^{bus.i_evt_data[31:29], bus.i_evt_data[26:25]};

  // End is kept 21 bits wide so start+length never wraps past time 2^20-1.
  assign w_ended      = {1'b0, r_time} >= r_end[r_k];
  assign w_live       = r_valid[r_k] & (r_time >= r_start[r_k]) & ~w_ended;
  assign w_voice_addr = r_base[r_k] + r_time - r_start[r_k];
  assign w_dq_shift   = $signed(bus.i_sram_dq) >>> r_vol[r_k];
  assign w_acc_next   = r_acc + {{4{w_dq_shift[15]}}, w_dq_shift};

  always_comb begin
    if (r_acc > 20'sd32767)       w_sat = 16'h7FFF;
    else if (r_acc < -20'sd32768) w_sat = 16'h8000;
    else                          w_sat = r_acc[15:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_k         <= '0;
      r_wait      <= '0;
      r_time      <= '0;
      r_raw       <= 1'b0;
      r_acc       <= '0;
      r_sram_addr <= '0;
      r_mix       <= '0;
      r_mix_valid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_base[i]  <= '0;
        r_vol[i]   <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;

      // Only possible in IDLE, so never collides with a retire in SCAN.
      if (w_evt_store) begin
        r_valid[w_free_idx] <= 1'b1;
        r_start[w_free_idx] <= bus.i_evt_data[19:0];
        r_end[w_free_idx]   <= {1'b0, bus.i_evt_data[19:0]} +
                               {1'b0, sound_length(bus.i_evt_data[24:20])};
        r_base[w_free_idx]  <= sound_addr(bus.i_evt_data[24:20]);
        r_vol[w_free_idx]   <= bus.i_evt_data[28:27];
      end

      case (r_state)
        S_IDLE: begin
          if (bus.i_tick) begin
            r_time  <= bus.i_time;
            r_raw   <= bus.i_play_stored;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= bus.i_play_stored ? S_RAW : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_live) begin
            r_sram_addr <= w_voice_addr;
            r_wait      <= WW'(SRAM_LAT);
            r_state     <= S_WAIT;
          end else begin
            if (r_valid[r_k] && w_ended) r_valid[r_k] <= 1'b0;
            if (r_k == LAST) r_state <= S_DONE;
            else             r_k     <= r_k + KW'(1);
          end
        end
        S_WAIT: begin
          if (r_wait == WW'(1)) r_state <= r_raw ? S_DONE : S_ACC;
          else                  r_wait  <= r_wait - WW'(1);
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_k == LAST) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + KW'(1);
            r_state <= S_SCAN;
          end
        end
        S_RAW: begin
          r_sram_addr <= r_time;
          r_wait      <= WW'(SRAM_LAT);
          r_state     <= S_WAIT;
        end
        S_DONE: begin
          // Raw data is a single unshifted 16-bit sample, so it never needs clamping.
          r_mix       <= r_raw ? bus.i_sram_dq : w_sat;
          r_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_evt_ready  = w_ready;
  assign bus.o_sram_addr  = r_sram_addr;
  assign bus.o_mix        = r_mix;
  assign bus.o_mix_valid  = r_mix_valid;
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_overrun    = bus.i_tick & (r_state != S_IDLE);
  assign bus.o_active_cnt = w_cnt;

endmodule

// File: tb/tb_sfx_voice_scheduler.sv
module tb_sfx_voice_scheduler;
  import sound_pkg::*;

  localparam int NV  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sfx_voice_scheduler_if bus();

  sfx_voice_scheduler #(.NUM_VOICES(NV), .SRAM_LAT(LAT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_mv  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_mix_valid) n_mv <= n_mv + 1;
  end

  // SRAM model: data is a hash of the address, appearing LAT cycles after the address.
  logic [19:0] pipe [LAT];
  logic        force_en = 1'b0;
  logic [15:0] force_dq = 16'h0000;

  always @(posedge clk) begin
    pipe[0] <= bus.o_sram_addr;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  function automatic logic [15:0] ram16(input logic [19:0] a);
    logic [31:0] h;
    h = {12'h0, a} * 32'h9E3779B1;
    return h[31:16];
  endfunction

  always_comb bus.i_sram_dq = force_en ? force_dq : ram16(pipe[LAT-1]);

  // Reference model: slot table in plain integers.
  int m_valid [NV];
  int m_start [NV];
  int m_end   [NV];
  int m_base  [NV];
  int m_vol   [NV];

  function automatic int dq_at(input int a);
    if (force_en) return int'($signed(force_dq));
    return int'($signed(ram16(20'(a))));
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int k = 0; k < NV; k++) c += m_valid[k];
    return c;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NV; k++) m_valid[k] = 0;
  endtask

  task automatic model_accept(input logic [32:0] d);
    if (d[32] || d == 33'd0) return;
    for (int k = 0; k < NV; k++) begin
      if (m_valid[k] == 0) begin
        m_valid[k] = 1;
        m_start[k] = int'(d[19:0]);
        m_end[k]   = int'(d[19:0]) + int'(sound_length(d[24:20]));
        m_base[k]  = int'(sound_addr(d[24:20]));
        m_vol[k]   = int'(d[28:27]);
        return;
      end
    end
  endtask

  task automatic model_tick(input int t, input bit raw, output int mix, output int lat);
    int sum = 0;
    if (raw) begin
      mix = dq_at(t);
      lat = 3 + LAT;
      return;
    end
    lat = 2;
    for (int k = 0; k < NV; k++) begin
      if (m_valid[k] != 0 && t >= m_end[k]) begin
        m_valid[k] = 0;
        lat += 1;
      end else if (m_valid[k] != 0 && t >= m_start[k]) begin
        sum += dq_at((m_base[k] + t - m_start[k]) % (1 << 20)) >>> m_vol[k];
        lat += 2 + LAT;
      end else begin
        lat += 1;
      end
    end
    mix = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] mk_evt(input bit mute, input int vol, input int btn, input int start);
    return {mute, 3'b000, 2'(vol), 2'b00, 5'(btn), 20'(start)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_evt(input string tag, input logic [32:0] d);
    bit ok = 0;
    bus.i_evt_valid = 1'b1;
    bus.i_evt_data  = d;
    for (int n = 0; n < 50; n++) begin
      if (bus.o_evt_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_ready"}, int'(ok), 1);
    if (ok) begin
      @(posedge clk); #1;
      model_accept(d);
    end
    bus.i_evt_valid = 1'b0;
    bus.i_evt_data  = 33'h0_DEAD_BEEF;
    chk({tag, "_cnt"}, int'(bus.o_active_cnt), model_cnt());
  endtask

  task automatic tick_and_check(input string tag, input int t, input bit raw, input int inject);
    int exp_mix, exp_lat, c0, mv0;
    bit got = 0;
    model_tick(t, raw, exp_mix, exp_lat);
    bus.i_tick        = 1'b1;
    bus.i_time        = 20'(t);
    bus.i_play_stored = raw;
    c0  = cyc;
    mv0 = n_mv;
    @(posedge clk); #1;
    bus.i_tick        = 1'b0;
    bus.i_time        = 20'($urandom);
    bus.i_play_stored = 1'($urandom);
    for (int n = 0; n < 100; n++) begin
      if (bus.o_mix_valid) begin got = 1; break; end
      if (inject > 0 && cyc - c0 == inject) begin
        bus.i_tick = 1'b1;
        #1;
        chk({tag, "_overrun"}, int'(bus.o_overrun), 1);
        chk({tag, "_busy"}, int'(bus.o_busy), 1);
      end
      @(posedge clk); #1;
      bus.i_tick = 1'b0;
    end
    chk({tag, "_mix_valid_seen"}, int'(got), 1);
    if (got) begin
      chk({tag, "_latency"}, cyc - c0, exp_lat);
      chk({tag, "_mix"}, int'($signed(bus.o_mix)), exp_mix);
      chk({tag, "_idle"}, int'(bus.o_busy), 0);
      chk({tag, "_active"}, int'(bus.o_active_cnt), model_cnt());
      @(posedge clk); #1;
      chk({tag, "_pulse_width"}, int'(bus.o_mix_valid), 0);
      chk({tag, "_pulse_count"}, n_mv - mv0, 1);
      chk({tag, "_no_overrun"}, int'(bus.o_overrun), 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int now, mv0;
    bus.i_tick        = 1'b0;
    bus.i_time        = '0;
    bus.i_play_stored = 1'b0;
    bus.i_evt_valid   = 1'b0;
    bus.i_evt_data    = '0;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_mix", int'(bus.o_mix), 0);
    chk("rst_mix_valid", int'(bus.o_mix_valid), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_addr", int'(bus.o_sram_addr), 0);
    chk("rst_cnt", int'(bus.o_active_cnt), 0);
    chk("rst_ready", int'(bus.o_evt_ready), 1);
    chk("rst_overrun", int'(bus.o_overrun), 0);

    // Single voice
    force_en = 1'b1; force_dq = 16'hFCE0;  // -800
    send_evt("t2_evt", mk_evt(0, 1, 3, 100));
    tick_and_check("t2", 105, 0, 0);
    chk("t2_addr", int'(bus.o_sram_addr), (3 << 15) + 5);
    chk("t2_mix_const", int'($signed(bus.o_mix)), -400);

    // Pending slot plus dropped tick
    do_reset();
    force_dq = 16'd1234;
    send_evt("t5_evt", mk_evt(0, 0, 1, 500));
    tick_and_check("t5_pending", 400, 0, 3);
    chk("t5_kept", int'(bus.o_active_cnt), 1);
    tick_and_check("t5_live", 520, 0, 0);

    // Saturation, full table, retire
    do_reset();
    for (int b = 0; b < 4; b++) send_evt("t3_evt", mk_evt(0, 0, b, 10));
    chk("t4_full_ready", int'(bus.o_evt_ready), 0);
    chk("t4_full_cnt", int'(bus.o_active_cnt), 4);
    force_dq = 16'd20000;
    tick_and_check("t3_pos", 20, 0, 0);
    chk("t3_pos_const", int'($signed(bus.o_mix)), 32767);
    force_dq = 16'hB1E0;  // -20000
    tick_and_check("t3_neg", 21, 0, 0);
    chk("t3_neg_const", int'($signed(bus.o_mix)), -32768);
    force_dq = 16'd5000;
    tick_and_check("t4_retire", 610, 0, 0);
    chk("t4_retire_cnt", int'(bus.o_active_cnt), 3);
    chk("t4_retire_ready", int'(bus.o_evt_ready), 1);
    send_evt("t4_refill", mk_evt(0, 0, 7, 600));
    tick_and_check("t4_second", 650, 0, 0);

    // Raw mode, muted and empty events
    do_reset();
    force_dq = 16'h7FFF;
    send_evt("t6_evt", mk_evt(0, 2, 1, 0));
    tick_and_check("t6_raw", 32'h12345, 1, 0);
    chk("t6_raw_addr", int'(bus.o_sram_addr), 32'h12345);
    chk("t6_raw_mix", int'($signed(bus.o_mix)), 32767);
    send_evt("t6_mute", mk_evt(1, 0, 4, 50));
    chk("t6_mute_cnt", int'(bus.o_active_cnt), 1);
    send_evt("t6_zero", 33'd0);
    chk("t6_zero_cnt", int'(bus.o_active_cnt), 1);

    // Randomized traffic against the model
    do_reset();
    force_en = 1'b0;
    now = 1000;
    for (int it = 0; it < 60; it++) begin
      for (int e = 0; e < 2; e++) begin
        if (model_cnt() < NV && $urandom_range(0, 2) != 0)
          send_evt("rnd_evt", mk_evt($urandom_range(0, 7) == 0, $urandom_range(0, 3),
                                     $urandom_range(0, 31), now + $urandom_range(0, 400) - 150));
      end
      tick_and_check("rnd", now, $urandom_range(0, 7) == 0, ($urandom_range(0, 3) == 0) ? 3 : 0);
      now += $urandom_range(1, 300);
    end

    // Reset in the middle of a scan
    do_reset();
    force_en = 1'b1; force_dq = 16'd1000;
    send_evt("t1_evt", mk_evt(0, 0, 2, 0));
    tick_and_check("t1_pre", 50, 0, 0);
    bus.i_tick = 1'b1; bus.i_time = 20'd60;
    @(posedge clk); #1;
    bus.i_tick = 1'b0;
    mv0 = n_mv;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_busy_before", int'(bus.o_busy), 1);
    rst = 1'b1;
    #1;
    chk("t1_mix", int'(bus.o_mix), 0);
    chk("t1_busy", int'(bus.o_busy), 0);
    chk("t1_cnt", int'(bus.o_active_cnt), 0);
    chk("t1_mix_valid", int'(bus.o_mix_valid), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_no_pulse", n_mv - mv0, 0);
    tick_and_check("t1_after", 70, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
